cpu_trace_buffer: RTL and testbench

//  Parametrised trace capture for the 16-bit CPU datapath. Taps fetch/execute signals (instr_addr,

---
 rtl/cpu_trace_pkg.sv | 40 ++++
 rtl/cpu_trace_fifo.sv | 65 ++++++
 rtl/cpu_trace_buffer.sv | 123 ++++++++++++
 tb/tb_cpu_trace_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace buffer: FSM state encoding, entry width and entry layout.
// With CPU_TRACE_TIMESTAMP_EN defined, entries carry a trailing timestamp field.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

`ifdef CPU_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 4;
  localparam int TS_W_DEF   = 16;

  function automatic int entry_width(int addr_w, int data_w, int op_w, int ts_w);
    return addr_w + 2 * data_w + op_w + 1 + (TS_EN ? ts_w : 0);
  endfunction

  localparam int ENTRY_W = entry_width(ADDR_W_DEF, DATA_W_DEF, OP_W_DEF, TS_W_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] instr_addr;
    logic [DATA_W_DEF-1:0] instruction;
    logic [OP_W_DEF-1:0]   op_select;
    logic [DATA_W_DEF-1:0] bus_d;
    logic                  zero;
`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [TS_W_DEF-1:0]   ts;
`endif
  } trace_entry_t;

endpackage

// File: rtl/cpu_trace_fifo.sv
// Synchronous show-ahead FIFO with flush; a word written at one edge is at the head after it.
// Writes are ignored when full unless a pop happens on the same edge; empty reads return zero.
module cpu_trace_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       wr_vld_i,
  input  logic [WIDTH-1:0]           wr_dat_i,
  output logic                       rd_vld_o,
  input  logic                       rd_rdy_i,
  output logic [WIDTH-1:0]           rd_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop, push, full;

  assign full     = (count_q == CW'(DEPTH));
  assign rd_vld_o = (count_q != '0);
  assign pop      = rd_vld_o && rd_rdy_i;
  assign push     = wr_vld_i && (!full || pop);
  assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Address-triggered trace capture of CPU fetch/execute taps into a FIFO drained over valid/ready.
// One-cycle write latency; drops on full FIFO set sticky overflow. CPU_TRACE_TIMESTAMP_EN adds timestamps.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 8,
  parameter int TS_W   = 16,
  localparam int EW    = entry_width(ADDR_W, DATA_W, OP_W, TS_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [LEN_W-1:0]  cap_len,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instruction,
  input  logic [OP_W-1:0]   op_select,
  input  logic [DATA_W-1:0] bus_d,
  input  logic              zero,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [EW-1:0]     rd_data,
  output logic [1:0]        state,
  output logic [LEN_W-1:0]  captured,
  output logic              overflow
);
  localparam int CW = $clog2(DEPTH + 1);

  trace_state_e     state_q, state_d;
  logic [LEN_W-1:0] captured_q, captured_d;
  logic             overflow_q, overflow_d;
  logic             flush, wr_vld, trig_hit, fifo_full;
  logic [EW-1:0]    wr_dat;
  logic [CW-1:0]    fifo_count;

  assign trig_hit  = cpu_valid && (instr_addr == trig_addr);
  assign fifo_full = (fifo_count == CW'(DEPTH));

`ifdef CPU_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ts_q <= '0;
    else if (arm)  ts_q <= '0;
    else           ts_q <= ts_q + TS_W'(1);
  end

  assign wr_dat = {instr_addr, instruction, op_select, bus_d, zero, ts_q};
`else
  assign wr_dat = {instr_addr, instruction, op_select, bus_d, zero};
`endif

  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    overflow_d = overflow_q;
    flush      = 1'b0;
    wr_vld     = 1'b0;
    if (arm) begin
      state_d    = ARMED;
      captured_d = '0;
      overflow_d = 1'b0;
      flush      = 1'b1;
    end else if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ARMED:   wr_vld = trig_hit;
        CAPTURE: wr_vld = cpu_valid;
        default: wr_vld = 1'b0;
      endcase
      if (wr_vld) begin
        state_d = CAPTURE;
        if (fifo_full && !rd_ready) begin
          // Dropped samples do not count toward the window length.
          overflow_d = 1'b1;
        end else begin
          if (captured_q != '1) captured_d = captured_q + LEN_W'(1);
          if (cap_len != '0 && ({1'b0, captured_q} + (LEN_W+1)'(1)) == {1'b0, cap_len})
            state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      captured_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      overflow_q <= overflow_d;
    end
  end

  cpu_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .flush_i  (flush),
    .wr_vld_i (wr_vld),
    .wr_dat_i (wr_dat),
    .rd_vld_o (rd_valid),
    .rd_rdy_i (rd_ready),
    .rd_dat_o (rd_data),
    .count_o  (fifo_count)
  );

  assign state    = state_q;
  assign captured = captured_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: reference model pushes expected entries, monitor pops on handshake.
module tb_cpu_trace_buffer;
  import cpu_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int EW    = ENTRY_W;

  logic        clk = 1'b0, reset_n = 1'b0, arm = 1'b0, abort = 1'b0;
  logic        cpu_valid = 1'b0, rd_ready = 1'b0, zero = 1'b0;
  logic [15:0] trig_addr = '0, instr_addr = '0, instruction = '0, bus_d = '0;
  logic [3:0]  op_select = '0;
  logic [7:0]  cap_len = '0;
  logic          rd_valid, overflow;
  logic [EW-1:0] rd_data;
  logic [1:0]    state;
  logic [7:0]    captured;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: trace mode 0..3, window count, sticky drop flag, FIFO contents as a queue.
  logic [EW-1:0] exp_q[$];
  int          m_state, m_cap, m_occ;
  bit          m_ovf;
  logic [15:0] m_ts;

  always #5 clk = ~clk;

  cpu_trace_buffer dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .trig_addr(trig_addr),
    .cap_len(cap_len), .cpu_valid(cpu_valid), .instr_addr(instr_addr),
    .instruction(instruction), .op_select(op_select), .bus_d(bus_d), .zero(zero),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .state(state),
    .captured(captured), .overflow(overflow)
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    bit pop, full, take;
    trace_entry_t t;
    if (!reset_n) begin
      m_state = 0; m_cap = 0; m_occ = 0; m_ovf = 1'b0; m_ts = '0;
      exp_q.delete();
    end else if (arm) begin
      m_state = 1; m_cap = 0; m_occ = 0; m_ovf = 1'b0; m_ts = '0;
      exp_q.delete();
    end else begin
      pop  = rd_ready && (m_occ > 0);
      full = (m_occ == DEPTH);
      take = cpu_valid && (m_state == 2 || (m_state == 1 && instr_addr == trig_addr));
      if (abort && m_state != 0) begin
        m_state = 0;
        take = 1'b0;
      end
      if (pop) m_occ--;
      if (take) begin
        m_state = 2;
        if (full && !pop) m_ovf = 1'b1;
        else begin
          t.instr_addr = instr_addr; t.instruction = instruction; t.op_select = op_select;
          t.bus_d = bus_d; t.zero = zero;
`ifdef CPU_TRACE_TIMESTAMP_EN
          t.ts = m_ts;
`endif
          exp_q.push_back(t);
          m_occ++;
          if (m_cap < 255) m_cap++;
          if (cap_len != 0 && m_cap == int'(cap_len)) m_state = 3;
        end
      end
      m_ts = m_ts + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("state", state, m_state);
      chk("captured", captured, m_cap);
      chk("overflow", overflow, m_ovf);
      chk("rd_valid", rd_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("rd_data", rd_data, exp_q[0]);
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    arm = 1'b0;
    abort = 1'b0;
  endtask

  task automatic sample(input logic [15:0] a);
    cpu_valid   = 1'b1;
    instr_addr  = a;
    instruction = 16'($urandom);
    op_select   = 4'($urandom);
    bus_d       = 16'($urandom);
    zero        = 1'($urandom);
  endtask

  task automatic drain(input string nm);
    cpu_valid = 1'b0;
    rd_ready  = 1'b1;
    for (int i = 0; i < DEPTH + 4 && rd_valid; i++) tick();
    chk(nm, rd_valid, 1'b0);
  endtask

  initial begin
    int k;
    #2;
    chk("rst_state", state, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_captured", captured, 0);
    chk("rst_overflow", overflow, 0);
    #10 reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // 1: four-entry window starting at the trigger address
    trig_addr = 16'h0040; cap_len = 8'd4; rd_ready = 1'b0; arm = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      sample(16'h003E + 16'(2 * i));
      tick();
      if (i == 4) chk("t1_done_edge", state, 3);
    end
    cpu_valid = 1'b0;
    chk("t1_state", state, 3);
    chk("t1_captured", captured, 4);
    rd_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 10 && rd_valid; i++) begin
      chk("t1_order", rd_data[EW-1 -: 16], 16'h0040 + 16'(2 * k));
      k++;
      tick();
    end
    chk("t1_entries", k, 4);

    // 2: unbounded window overflows the FIFO, first DEPTH samples kept
    trig_addr = 16'h0100; cap_len = 8'd0; rd_ready = 1'b0; arm = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      sample(16'h0100 + 16'(2 * i));
      tick();
    end
    chk("t2_overflow", overflow, 1);
    chk("t2_captured", captured, 16);
    chk("t2_head", rd_data[EW-1 -: 16], 16'h0100);

    // 3: full FIFO with reader ready: one pop and one push per cycle
    rd_ready = 1'b1;
    for (int i = 20; i < 30; i++) begin
      sample(16'h0100 + 16'(2 * i));
      tick();
    end
    chk("t3_captured", captured, 26);
    cpu_valid = 1'b0; abort = 1'b1;
    tick();
    chk("t3_abort_idle", state, 0);
    drain("t3_drained");

    // 4: re-arm in the middle of a capture
    trig_addr = 16'h0200; cap_len = 8'd0; rd_ready = 1'b0; arm = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      sample(16'h0200 + 16'(2 * i));
      tick();
    end
    sample(16'h0206); arm = 1'b1;
    tick();
    cpu_valid = 1'b0;
    chk("t4_empty", rd_valid, 0);
    chk("t4_state", state, 1);
    chk("t4_captured", captured, 0);
    chk("t4_overflow", overflow, 0);

    // 5: asynchronous reset pulse between clock edges
    sample(16'h0200);
    tick();
    sample(16'h0202);
    tick();
    cpu_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_state", state, 0);
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_rd_data", rd_data, 0);
    chk("t5_captured", captured, 0);
    chk("t5_overflow", overflow, 0);
    reset_n = 1'b1;
    tick();

`ifdef CPU_TRACE_TIMESTAMP_EN
    // 6: trigger sampled when the counter, cleared by arm, reads 5
    trig_addr = 16'h0300; cap_len = 8'd1; rd_ready = 1'b0; arm = 1'b1;
    tick();
    repeat (5) tick();
    sample(16'h0300);
    tick();
    cpu_valid = 1'b0;
    chk("t6_ts", rd_data[15:0], 16'd5);
    drain("t6_drained");
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      arm   = ($urandom_range(0, 39) == 0);
      abort = !arm && ($urandom_range(0, 59) == 0);
      if (arm) begin
        cap_len   = 8'($urandom_range(0, 20));
        trig_addr = 16'($urandom_range(0, 7) * 2);
      end
      sample(16'($urandom_range(0, 7) * 2));
      cpu_valid = ($urandom_range(0, 3) != 0);
      rd_ready  = 1'($urandom_range(0, 1));
      tick();
    end
    abort = 1'b1;
    tick();
    drain("final_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
